uncache_bridge: RTL and testbench
=================================

// Module: uncache_bridge
// PURPOSE
//  Memory-side endpoint for CPU data accesses the address translator has flagged uncached (kseg1, no_dcache=1).
//  Accepts a physical-address request on the CPU-side sram-like port and replays it, one at a time, on the
//  bus-side sram-like port. It then returns read data and completion to the CPU.
//  Sits between the data-path mux (dcache vs uncached) and the AXI/sram-like bus arbiter.
// PARAMETERS
//  ADDR_W  32  physical address width (translated address, top 3 bits already cleared for kseg0/1)
//  DATA_W  32  data width; must be 32
// PORTS
//  clk            in   1       single clock; all state on posedge
//  resetn         in   1       asynchronous, active-low reset
//  cpu_req        in   1       CPU request valid
//  cpu_wr         in   1       1=store, 0=load
//  cpu_size       in   2       0=byte 1=half 2=word
//  cpu_addr       in   ADDR_W  physical address
//  cpu_wdata      in   DATA_W  store data
//  cpu_addr_ok    out  1       request accepted this cycle
//  cpu_data_ok    out  1       one-cycle completion pulse
//  cpu_rdata      out  DATA_W  load data, valid with cpu_data_ok
//  bus_req        out  1       bus request valid
//  bus_wr         out  1
//  bus_size       out  2
//  bus_addr       out  ADDR_W
//  bus_wdata      out  DATA_W
//  bus_addr_ok    in   1       bus accepted address
//  bus_data_ok    in   1       bus completed transfer
//  bus_rdata      in   DATA_W
// BEHAVIOUR
//  Reset: state=IDLE; cpu_addr_ok=0, cpu_data_ok=0, cpu_rdata=0, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0.
//  FSM states:
//   IDLE : cpu_addr_ok=1 (combinational on state). cpu_req&cpu_addr_ok latches wr/size/addr/wdata -> REQ.
//   REQ  : bus_req=1 with latched fields held stable. bus_addr_ok -> WAIT.
//   WAIT : bus_req=0. bus_data_ok -> IDLE; capture cpu_rdata<=bus_rdata (loads only; stores leave it unchanged).
//          cpu_data_ok<=1 for exactly one cycle, registered.
//  Protocol rules:
//   - One outstanding transaction; cpu_addr_ok=0 in REQ/WAIT.
//   - bus_data_ok is ignored outside WAIT, including same cycle as bus_addr_ok.
//   - bus_addr_ok is ignored outside REQ.
//   - Fields on bus_* change only on IDLE->REQ.
//  Minimum latency: accept @T, bus_req @T+1, addr_ok @T+1, data_ok @T+2, cpu_data_ok @T+3.
//  Back-to-back: new cpu_req may be accepted in the same cycle cpu_data_ok is high (state is IDLE).
//  cpu_size/addr are passed through unmodified. No alignment check; that is the exception unit's job.
//  Reset mid-operation: all outputs return to reset values asynchronously; the in-flight bus transfer is abandoned.
// CONFIGURATION
//  UNCACHE_POSTED_WR_EN defined:
//   - Accepted stores get cpu_data_ok the cycle after acceptance, before the bus completes.
//   - The store sits in a 1-entry write buffer and drains via REQ/WAIT; its bus_data_ok produces no CPU pulse.
//   - Any further cpu_req stalls (cpu_addr_ok=0) until the drain's bus_data_ok, preserving program order.
//  Undefined: stores complete only on bus_data_ok, identical to loads.
// STRUCTURE
//  Package uncache_pkg:
//   - state encoding (IDLE/REQ/WAIT)
//   - SIZE_B/H/W constants
//   - request-record struct {wr,size,addr,wdata}
//  Sub-module uncache_wbuf (1-entry posted-write holder, valid flag + record), instantiated only under UNCACHE_POSTED_WR_EN.
// TESTING
//  1 Load 0x1FC0_0000 word, bus addr_ok same cycle as bus_req, data_ok next cycle with 0xDEAD_BEEF
//    -> cpu_data_ok 3 cycles after accept, cpu_rdata=0xDEAD_BEEF.
//  2 Store byte 0x1FAF_0010 wdata=0x5A with bus_addr_ok delayed 4 cycles
//    -> bus_req held 5 cycles, fields stable, single cpu_data_ok pulse.
//  3 Back-to-back loads 0x100/0x104
//    -> second cpu_addr_ok coincides with first cpu_data_ok; two bus requests, in order.
//  4 Spurious bus_data_ok in IDLE and REQ
//    -> no cpu_data_ok, state unchanged.
//  5 resetn low while in WAIT
//    -> bus_req=0, cpu_data_ok=0 immediately; after release cpu_addr_ok=1.
//  6 POSTED_WR_EN: store then load
//    -> store cpu_data_ok at T+1; load not accepted until store drain bus_data_ok; load data returned correctly.

Source files
------------

// File: rtl/uncache_pkg.sv
// rtl/uncache_pkg.sv - shared types and constants for the uncached access bridge
//
// Holds the FSM state encoding, the transfer size codes and the request
// record that the bridge latches on acceptance and replays on the bus.
package uncache_pkg;

  localparam int REC_ADDR_W = 32;
  localparam int REC_DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [REC_ADDR_W-1:0] addr;
    logic [REC_DATA_W-1:0] wdata;
  } req_rec_t;

  function automatic req_rec_t make_rec(input logic                  wr,
                                        input logic [1:0]            size,
                                        input logic [REC_ADDR_W-1:0] addr,
                                        input logic [REC_DATA_W-1:0] wdata);
    req_rec_t r;
    r.wr    = wr;
    r.size  = size;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/uncache_wbuf.sv
// rtl/uncache_wbuf.sv - single-entry posted-write holder
//
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   push_i        load rec_i and mark the entry valid (store accepted)
//   pop_i         clear the entry (drain completed on the bus)
//   rec_i         store record to hold
//   valid_o       entry is occupied; the in-flight transfer is a posted store
//   rec_o         held store record
module uncache_wbuf
  import uncache_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  input  logic     push_i,
  input  logic     pop_i,
  input  req_rec_t rec_i,
  output logic     valid_o,
  output req_rec_t rec_o
);

  logic     valid_q, valid_d;
  req_rec_t rec_q, rec_d;

  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    if (push_i) begin
      valid_d = 1'b1;
      rec_d   = rec_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;

endmodule

// File: rtl/uncache_bridge.sv
// rtl/uncache_bridge.sv - one-at-a-time replay of uncached CPU accesses onto the bus port
//
// Optional feature macro: UNCACHE_POSTED_WR_EN (posted stores via uncache_wbuf).
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   cpu_req/wr/size/addr/wdata  CPU-side request
//   cpu_addr_ok                 request accepted this cycle (IDLE only)
//   cpu_data_ok, cpu_rdata      one-cycle completion pulse and load data
//   bus_req/wr/size/addr/wdata  bus-side request, fields held from acceptance
//   bus_addr_ok, bus_data_ok    bus address accept / transfer complete
//   bus_rdata                   bus read data
module uncache_bridge
  import uncache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e            state_q;
  req_rec_t          req_q;
  logic              bus_req_q;
  logic              data_ok_q;
  logic [DATA_W-1:0] rdata_q;

  req_rec_t new_rec;
  req_rec_t out_rec;
  logic     accept;
  logic     posted_cur;

  assign new_rec = make_rec(cpu_wr, cpu_size, REC_ADDR_W'(cpu_addr), REC_DATA_W'(cpu_wdata));
  assign accept  = cpu_req & cpu_addr_ok;

`ifdef UNCACHE_POSTED_WR_EN
  localparam logic POSTED_WR = 1'b1;

  logic     wb_valid;
  req_rec_t wb_rec;

  uncache_wbuf u_wbuf (
    .clk    (clk),
    .resetn (resetn),
    .push_i (accept & cpu_wr),
    .pop_i  ((state_q == ST_WAIT) & bus_data_ok),
    .rec_i  (new_rec),
    .valid_o(wb_valid),
    .rec_o  (wb_rec)
  );

  // A held store blocks every new request until its drain completes, so
  // program order between the posted store and later accesses is kept.
  assign cpu_addr_ok = resetn & (state_q == ST_IDLE) & ~wb_valid;
  assign posted_cur  = wb_valid;
  assign out_rec     = wb_valid ? wb_rec : req_q;
`else
  localparam logic POSTED_WR = 1'b0;

  // Gated by resetn so the port reads not-ready while reset is held.
  assign cpu_addr_ok = resetn & (state_q == ST_IDLE);
  assign posted_cur  = 1'b0;
  assign out_rec     = req_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      bus_req_q <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_q     <= new_rec;
            bus_req_q <= 1'b1;
            state_q   <= ST_REQ;
            // Posted stores complete towards the CPU right away.
            data_ok_q <= POSTED_WR & cpu_wr;
          end
        end
        ST_REQ: begin
          if (bus_addr_ok) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_data_ok) begin
            state_q   <= ST_IDLE;
            data_ok_q <= ~posted_cur;
            if (!req_q.wr) begin
              rdata_q <= bus_rdata;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_data_ok = data_ok_q;
  assign cpu_rdata   = rdata_q;
  assign bus_req     = bus_req_q;
  assign bus_wr      = out_rec.wr;
  assign bus_size    = out_rec.size;
  assign bus_addr    = out_rec.addr[ADDR_W-1:0];
  assign bus_wdata   = out_rec.wdata[DATA_W-1:0];

endmodule

// File: tb/tb_uncache_bridge.sv
// tb/tb_uncache_bridge.sv - self-checking bench for uncache_bridge
module tb_uncache_bridge;
  import uncache_pkg::*;

`ifdef UNCACHE_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  always #5 clk = ~clk;

  uncache_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_size   (cpu_size),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok),
    .cpu_rdata  (cpu_rdata),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_size   (bus_size),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata  (bus_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one access outstanding at a time; it is
  // offered to the bus until the bus takes the address, then completes on
  // the first later bus_data_ok.
  bit          m_pending = 1'b0;
  bit          m_granted = 1'b0;
  bit          m_posted  = 1'b0;
  bit          m_pulse   = 1'b0;
  logic        m_wr      = 1'b0;
  logic [1:0]  m_size    = 2'd0;
  logic [31:0] m_addr    = 32'd0;
  logic [31:0] m_wdata   = 32'd0;
  logic [31:0] m_rdata   = 32'd0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pending = 1'b0;
      m_granted = 1'b0;
      m_posted  = 1'b0;
      m_pulse   = 1'b0;
      m_wr      = 1'b0;
      m_size    = 2'd0;
      m_addr    = 32'd0;
      m_wdata   = 32'd0;
      m_rdata   = 32'd0;
    end else begin
      m_pulse = 1'b0;
      if (!m_pending) begin
        if (cpu_req) begin
          m_pending = 1'b1;
          m_granted = 1'b0;
          m_wr      = cpu_wr;
          m_size    = cpu_size;
          m_addr    = cpu_addr;
          m_wdata   = cpu_wdata;
          m_posted  = POSTED && cpu_wr;
          m_pulse   = m_posted;
        end
      end else if (!m_granted) begin
        if (bus_addr_ok) m_granted = 1'b1;
      end else if (bus_data_ok) begin
        m_pending = 1'b0;
        m_granted = 1'b0;
        if (!m_posted) m_pulse = 1'b1;
        if (!m_wr) m_rdata = bus_rdata;
      end
    end
  end

  always @(negedge clk) begin
    chk("cpu_addr_ok", 32'(cpu_addr_ok), 32'(resetn && !m_pending));
    chk("cpu_data_ok", 32'(cpu_data_ok), 32'(m_pulse));
    chk("cpu_rdata",   cpu_rdata,        m_rdata);
    chk("bus_req",     32'(bus_req),     32'(m_pending && !m_granted));
    chk("bus_wr",      32'(bus_wr),      32'(m_wr));
    chk("bus_size",    32'(bus_size),    32'(m_size));
    chk("bus_addr",    bus_addr,         m_addr);
    chk("bus_wdata",   bus_wdata,        m_wdata);
  end

  task automatic set_cpu(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  logic [1:0] sizes [3];
  int cnt_req;
  int pulses;

  initial begin
    sizes[0] = SIZE_B;
    sizes[1] = SIZE_H;
    sizes[2] = SIZE_W;

    // Reset state
    @(negedge clk);
    chk("rst_addr_ok", 32'(cpu_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(cpu_data_ok), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;

    // 1: single load, fastest bus
    @(negedge clk);
    chk("t1_addr_ok_idle", 32'(cpu_addr_ok), 32'd1);
    set_cpu(1'b0, SIZE_W, 32'h1FC0_0000, 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("t1_bus_req", 32'(bus_req), 32'd1);
    chk("t1_bus_addr", bus_addr, 32'h1FC0_0000);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    chk("t1_wait_req_low", 32'(bus_req), 32'd0);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("t1_data_ok_t3", 32'(cpu_data_ok), 32'd1);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_pulse_end", 32'(cpu_data_ok), 32'd0);

    // 2: store byte with bus_addr_ok delayed 4 cycles
    set_cpu(1'b1, SIZE_B, 32'h1FAF_0010, 32'h0000_005A);
    cnt_req = 0;
    pulses  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cpu_req     = 1'b0;
      cpu_addr    = $urandom;
      cpu_wdata   = $urandom;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (bus_req) begin
        cnt_req++;
        chk("t2_bus_wr", 32'(bus_wr), 32'd1);
        chk("t2_bus_size", 32'(bus_size), 32'(SIZE_B));
        chk("t2_bus_addr", bus_addr, 32'h1FAF_0010);
        chk("t2_bus_wdata", bus_wdata, 32'h0000_005A);
      end
      if (cpu_data_ok) pulses++;
      if (i == 4) bus_addr_ok = 1'b1;
      if (i == 5) bus_data_ok = 1'b1;
    end
    chk("t2_req_cycles", 32'(cnt_req), 32'd5);
    chk("t2_pulses", 32'(pulses), 32'd1);

    // 3: back-to-back loads
    @(negedge clk);
    set_cpu(1'b0, SIZE_W, 32'h0000_0100, 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("t3_first_addr", bus_addr, 32'h0000_0100);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h1111_0100;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("t3_first_data_ok", 32'(cpu_data_ok), 32'd1);
    chk("t3_addr_ok_with_data_ok", 32'(cpu_addr_ok), 32'd1);
    chk("t3_first_rdata", cpu_rdata, 32'h1111_0100);
    set_cpu(1'b0, SIZE_W, 32'h0000_0104, 32'h0);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("t3_second_req", 32'(bus_req), 32'd1);
    chk("t3_second_addr", bus_addr, 32'h0000_0104);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h2222_0104;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("t3_second_rdata", cpu_rdata, 32'h2222_0104);

    // 4: spurious bus_data_ok in IDLE, REQ and with bus_addr_ok
    @(negedge clk);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0BAD_0BAD;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("t4_idle_no_pulse", 32'(cpu_data_ok), 32'd0);
    chk("t4_idle_rdata_kept", cpu_rdata, 32'h2222_0104);
    set_cpu(1'b0, SIZE_H, 32'h0000_0200, 32'h0);
    @(negedge clk);
    cpu_req     = 1'b0;
    bus_data_ok = 1'b1;
    @(negedge clk);
    chk("t4_req_held", 32'(bus_req), 32'd1);
    chk("t4_req_no_pulse", 32'(cpu_data_ok), 32'd0);
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    chk("t4_wait_entered", 32'(bus_req), 32'd0);
    chk("t4_same_cycle_ignored", 32'(cpu_data_ok), 32'd0);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h3333_0200;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("t4_done", 32'(cpu_data_ok), 32'd1);
    chk("t4_rdata", cpu_rdata, 32'h3333_0200);

    // 5: reset while in WAIT, then while in REQ
    @(negedge clk);
    set_cpu(1'b0, SIZE_W, 32'h0000_0300, 32'h0);
    @(negedge clk);
    cpu_req     = 1'b0;
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_bus_req", 32'(bus_req), 32'd0);
    chk("t5_rst_data_ok", 32'(cpu_data_ok), 32'd0);
    chk("t5_rst_addr_ok", 32'(cpu_addr_ok), 32'd0);
    chk("t5_rst_bus_addr", bus_addr, 32'd0);
    chk("t5_rst_rdata", cpu_rdata, 32'd0);
    bus_data_ok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_data_ok = 1'b0;
    #2 resetn = 1'b1;
    @(negedge clk);
    chk("t5_release_addr_ok", 32'(cpu_addr_ok), 32'd1);
    chk("t5_release_no_pulse", 32'(cpu_data_ok), 32'd0);
    set_cpu(1'b1, SIZE_W, 32'h0000_0310, 32'h1234_5678);
    @(negedge clk);
    cpu_req = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_req_phase", 32'(bus_req), 32'd0);
    #2 resetn = 1'b1;

`ifdef UNCACHE_POSTED_WR_EN
    // 6: posted store followed by a load
    @(negedge clk);
    set_cpu(1'b1, SIZE_W, 32'h0000_0400, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t6_store_data_ok_t1", 32'(cpu_data_ok), 32'd1);
    chk("t6_stall", 32'(cpu_addr_ok), 32'd0);
    set_cpu(1'b0, SIZE_W, 32'h0000_0404, 32'h0);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    chk("t6_stall_wait", 32'(cpu_addr_ok), 32'd0);
    bus_data_ok = 1'b1;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("t6_drain_no_pulse", 32'(cpu_data_ok), 32'd0);
    chk("t6_load_accept", 32'(cpu_addr_ok), 32'd1);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("t6_load_addr", bus_addr, 32'h0000_0404);
    chk("t6_load_wr", 32'(bus_wr), 32'd0);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h4444_0404;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("t6_load_data_ok", 32'(cpu_data_ok), 32'd1);
    chk("t6_load_rdata", cpu_rdata, 32'h4444_0404);
`endif

    // Randomized traffic with random bus handshakes and one async reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cpu_req     = ($urandom_range(0, 2) == 0);
      cpu_wr      = 1'($urandom_range(0, 1));
      cpu_size    = sizes[$urandom_range(0, 2)];
      cpu_addr    = $urandom;
      cpu_wdata   = $urandom;
      bus_addr_ok = 1'($urandom_range(0, 1));
      bus_data_ok = 1'($urandom_range(0, 1));
      bus_rdata   = $urandom;
      if (c == 1500) begin
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
      end
    end

    @(negedge clk);
    cpu_req     = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
